// File: rtl/rename_map_table_if.sv
// rename_map_table_if: rename group, free-list handshake and commit bus seen by the map table.
interface rename_map_table_if #(
    parameter int PRF_W = 6
);
    typedef struct packed {
        logic             wr_reg_commit;
        logic [4:0]       committed_arf;
        logic [PRF_W-1:0] committed_prf;
    } commit_info_t;

    logic             recover;
    logic             pause;
    logic             inst_0_valid, inst_1_valid;
    logic             inst_0_wr_reg, inst_1_wr_reg;
    logic [4:0]       inst_0_rs, inst_0_rt, inst_0_rd;
    logic [4:0]       inst_1_rs, inst_1_rt, inst_1_rd;
    logic             inst_0_req, inst_1_req;
    logic [PRF_W-1:0] inst_0_new_prf, inst_1_new_prf;
    logic             allocatable;
    logic [PRF_W-1:0] inst_0_prs, inst_0_prt, inst_1_prs, inst_1_prt;
    logic [PRF_W-1:0] inst_0_prd, inst_1_prd;
    logic [PRF_W-1:0] inst_0_stale_prf, inst_1_stale_prf;
    logic             rename_fire;
    logic             commit_valid_0, commit_valid_1;
    commit_info_t     commit_info_0, commit_info_1;

    modport master (
        output recover, pause,
        output inst_0_valid, inst_1_valid, inst_0_wr_reg, inst_1_wr_reg,
        output inst_0_rs, inst_0_rt, inst_0_rd, inst_1_rs, inst_1_rt, inst_1_rd,
        output inst_0_new_prf, inst_1_new_prf, allocatable,
        output commit_valid_0, commit_valid_1, commit_info_0, commit_info_1,
        input  inst_0_req, inst_1_req,
        input  inst_0_prs, inst_0_prt, inst_1_prs, inst_1_prt,
        input  inst_0_prd, inst_1_prd, inst_0_stale_prf, inst_1_stale_prf,
        input  rename_fire
    );

    modport slave (
        input  recover, pause,
        input  inst_0_valid, inst_1_valid, inst_0_wr_reg, inst_1_wr_reg,
        input  inst_0_rs, inst_0_rt, inst_0_rd, inst_1_rs, inst_1_rt, inst_1_rd,
        input  inst_0_new_prf, inst_1_new_prf, allocatable,
        input  commit_valid_0, commit_valid_1, commit_info_0, commit_info_1,
        output inst_0_req, inst_1_req,
        output inst_0_prs, inst_0_prt, inst_1_prs, inst_1_prt,
        output inst_0_prd, inst_1_prd, inst_0_stale_prf, inst_1_stale_prf,
        output rename_fire
    );
endinterface

// File: rtl/rename_map_table.sv
// rename_map_table: two-wide register alias table with speculative and committed maps.
module rename_map_table #(
    parameter int ARF_NUM = 32,
    parameter int PRF_NUM = 64,
    parameter int PRF_W   = $clog2(PRF_NUM)
) (
    input logic clk,
    input logic rst,
    rename_map_table_if.slave m
);
    logic [PRF_W-1:0] spec_map [ARF_NUM];
    logic [PRF_W-1:0] comm_map [ARF_NUM];
    logic [PRF_W-1:0] comm_next [ARF_NUM];
    logic             req_0, req_1, fire;
    logic [PRF_W-1:0] rs0_map, rt0_map, rs1_map, rt1_map, rd0_map, rd1_map;

    assign req_0 = m.inst_0_valid & m.inst_0_wr_reg & (m.inst_0_rd != 5'd0);
    assign req_1 = m.inst_1_valid & m.inst_1_wr_reg & (m.inst_1_rd != 5'd0);
    assign fire  = ~rst & ~m.recover & ~m.pause & m.allocatable & (m.inst_0_valid | m.inst_1_valid);

    // r0 is forced to PRF 0 on read even though the map never writes it
    assign rs0_map = m.inst_0_rs == 5'd0 ? '0 : spec_map[m.inst_0_rs];
    assign rt0_map = m.inst_0_rt == 5'd0 ? '0 : spec_map[m.inst_0_rt];
    assign rs1_map = m.inst_1_rs == 5'd0 ? '0 : spec_map[m.inst_1_rs];
    assign rt1_map = m.inst_1_rt == 5'd0 ? '0 : spec_map[m.inst_1_rt];
    assign rd0_map = m.inst_0_rd == 5'd0 ? '0 : spec_map[m.inst_0_rd];
    assign rd1_map = m.inst_1_rd == 5'd0 ? '0 : spec_map[m.inst_1_rd];

    assign m.inst_0_req       = req_0;
    assign m.inst_1_req       = req_1;
    assign m.rename_fire      = fire;
    assign m.inst_0_prs       = rs0_map;
    assign m.inst_0_prt       = rt0_map;
    assign m.inst_1_prs       = req_0 && m.inst_1_rs == m.inst_0_rd ? m.inst_0_new_prf : rs1_map;
    assign m.inst_1_prt       = req_0 && m.inst_1_rt == m.inst_0_rd ? m.inst_0_new_prf : rt1_map;
    assign m.inst_0_prd       = req_0 ? m.inst_0_new_prf : '0;
    assign m.inst_1_prd       = req_1 ? m.inst_1_new_prf : '0;
    assign m.inst_0_stale_prf = req_0 ? rd0_map : '0;
    assign m.inst_1_stale_prf = !req_1 ? '0 :
                                req_0 && m.inst_1_rd == m.inst_0_rd ? m.inst_0_new_prf : rd1_map;

    // slot 1 is applied after slot 0 so it wins on a shared arf
    always_comb begin
        comm_next = comm_map;
        if (m.commit_valid_0 && m.commit_info_0.wr_reg_commit && m.commit_info_0.committed_arf != 5'd0)
            comm_next[m.commit_info_0.committed_arf] = m.commit_info_0.committed_prf;
        if (m.commit_valid_1 && m.commit_info_1.wr_reg_commit && m.commit_info_1.committed_arf != 5'd0)
            comm_next[m.commit_info_1.committed_arf] = m.commit_info_1.committed_prf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARF_NUM; i++) begin
                spec_map[i] <= '0;
                comm_map[i] <= '0;
            end
        end else begin
            comm_map <= comm_next;
            if (m.recover)
                spec_map <= comm_next;
            else if (fire) begin
                if (req_0) spec_map[m.inst_0_rd] <= m.inst_0_new_prf;
                if (req_1) spec_map[m.inst_1_rd] <= m.inst_1_new_prf;
            end
        end
    end
endmodule

// File: tb/tb_rename_map_table.sv
// tb_rename_map_table: table-driven rename/commit/recover vectors checked through a scoreboard queue.
module tb_rename_map_table;
    typedef struct {int v, w, rs, rt, rd, n;} slot_t;
    typedef struct {int v, w, a, p;} cmt_t;
    typedef struct {int prs0, prt0, prs1, prt1, prd0, prd1, st0, st1, req0, req1, fire;} exp_t;
    typedef struct {slot_t s0, s1; int pause, alloc, rec; cmt_t c0, c1; exp_t e;} vec_t;

    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    int idq[$];
    vec_t tbl[18];
    slot_t idle;
    cmt_t none;

    rename_map_table_if #(.PRF_W(6)) m ();
    rename_map_table #(.ARF_NUM(32), .PRF_NUM(64), .PRF_W(6)) dut (.clk(clk), .rst(rst), .m(m));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int id;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            id = idq.pop_front();
            chk("inst_0_prs", id, int'(m.inst_0_prs), e.prs0);
            chk("inst_0_prt", id, int'(m.inst_0_prt), e.prt0);
            chk("inst_1_prs", id, int'(m.inst_1_prs), e.prs1);
            chk("inst_1_prt", id, int'(m.inst_1_prt), e.prt1);
            chk("inst_0_prd", id, int'(m.inst_0_prd), e.prd0);
            chk("inst_1_prd", id, int'(m.inst_1_prd), e.prd1);
            chk("inst_0_stale", id, int'(m.inst_0_stale_prf), e.st0);
            chk("inst_1_stale", id, int'(m.inst_1_stale_prf), e.st1);
            chk("inst_0_req", id, int'(m.inst_0_req), e.req0);
            chk("inst_1_req", id, int'(m.inst_1_req), e.req1);
            chk("rename_fire", id, int'(m.rename_fire), e.fire);
        end
    end

    task automatic apply(input vec_t v, input int r, input int id);
        @(posedge clk);
        #1;
        rst = 1'(r);
        m.inst_0_valid = 1'(v.s0.v);
        m.inst_0_wr_reg = 1'(v.s0.w);
        m.inst_0_rs = 5'(v.s0.rs);
        m.inst_0_rt = 5'(v.s0.rt);
        m.inst_0_rd = 5'(v.s0.rd);
        m.inst_0_new_prf = 6'(v.s0.n);
        m.inst_1_valid = 1'(v.s1.v);
        m.inst_1_wr_reg = 1'(v.s1.w);
        m.inst_1_rs = 5'(v.s1.rs);
        m.inst_1_rt = 5'(v.s1.rt);
        m.inst_1_rd = 5'(v.s1.rd);
        m.inst_1_new_prf = 6'(v.s1.n);
        m.pause = 1'(v.pause);
        m.allocatable = 1'(v.alloc);
        m.recover = 1'(v.rec);
        m.commit_valid_0 = 1'(v.c0.v);
        m.commit_info_0.wr_reg_commit = 1'(v.c0.w);
        m.commit_info_0.committed_arf = 5'(v.c0.a);
        m.commit_info_0.committed_prf = 6'(v.c0.p);
        m.commit_valid_1 = 1'(v.c1.v);
        m.commit_info_1.wr_reg_commit = 1'(v.c1.w);
        m.commit_info_1.committed_arf = 5'(v.c1.a);
        m.commit_info_1.committed_prf = 6'(v.c1.p);
        sb.push_back(v.e);
        idq.push_back(id);
    endtask

    initial begin
        vec_t v;
        idle = '{0, 0, 0, 0, 0, 0};
        none = '{0, 0, 0, 0};
        //          slot0                  slot1                  pause alloc rec  commit0          commit1         prs0 prt0 prs1 prt1 prd0 prd1 st0 st1 rq0 rq1 fire
        tbl[0]  = '{'{1, 1, 3, 4, 5, 1},   idle,                  0, 1, 0, none,            none,           '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1}};
        tbl[1]  = '{'{1, 1, 5, 3, 7, 2},   '{1, 1, 7, 5, 7, 3},   0, 1, 0, none,            none,           '{1, 0, 2, 1, 2, 3, 0, 2, 1, 1, 1}};
        tbl[2]  = '{'{1, 1, 7, 0, 0, 5},   '{1, 1, 0, 7, 0, 6},   0, 1, 0, none,            none,           '{3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1}};
        tbl[3]  = '{'{1, 1, 0, 7, 9, 4},   idle,                  1, 1, 0, '{1, 1, 9, 6},   none,           '{0, 3, 0, 0, 4, 0, 0, 0, 1, 0, 0}};
        tbl[4]  = '{'{1, 0, 9, 5, 0, 0},   idle,                  0, 1, 0, none,            none,           '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1}};
        tbl[5]  = '{'{1, 1, 9, 0, 10, 8},  idle,                  0, 1, 0, none,            none,           '{0, 0, 0, 0, 8, 0, 0, 0, 1, 0, 1}};
        tbl[6]  = '{'{1, 1, 10, 0, 10, 11}, idle,                 0, 1, 0, none,            none,           '{8, 0, 0, 0, 11, 0, 8, 0, 1, 0, 1}};
        tbl[7]  = '{'{1, 1, 10, 7, 12, 13}, idle,                 0, 1, 1, '{1, 1, 10, 8},  '{1, 1, 5, 1},  '{11, 3, 0, 0, 13, 0, 0, 0, 1, 0, 0}};
        tbl[8]  = '{'{1, 0, 10, 7, 0, 0},  '{1, 0, 9, 12, 0, 0},  0, 1, 0, none,            none,           '{8, 0, 6, 0, 0, 0, 0, 0, 0, 0, 1}};
        tbl[9]  = '{'{1, 0, 5, 9, 0, 0},   idle,                  0, 1, 0, '{1, 1, 7, 20},  '{1, 1, 7, 21}, '{1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1}};
        tbl[10] = '{'{1, 1, 7, 0, 14, 22}, '{1, 1, 14, 14, 15, 23}, 0, 0, 0, none,          none,           '{0, 0, 22, 22, 22, 23, 0, 0, 1, 1, 0}};
        tbl[11] = '{'{1, 1, 7, 0, 14, 22}, '{1, 1, 14, 14, 15, 23}, 0, 1, 0, none,          none,           '{0, 0, 22, 22, 22, 23, 0, 0, 1, 1, 1}};
        tbl[12] = '{'{1, 0, 14, 15, 0, 0}, idle,                  0, 1, 1, none,            none,           '{22, 23, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[13] = '{'{1, 0, 14, 7, 0, 0},  '{1, 0, 15, 10, 0, 0}, 0, 1, 0, none,            none,           '{0, 21, 0, 8, 0, 0, 0, 0, 0, 0, 1}};
        tbl[14] = '{'{1, 1, 0, 0, 20, 30}, '{1, 1, 20, 0, 20, 31}, 0, 1, 0, none,           none,           '{0, 0, 30, 0, 30, 31, 0, 30, 1, 1, 1}};
        tbl[15] = '{'{1, 0, 20, 0, 0, 0},  idle,                  0, 1, 0, none,            none,           '{31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}};
        tbl[16] = '{idle,                  idle,                  0, 1, 1, '{1, 0, 20, 40}, '{1, 1, 0, 41}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[17] = '{'{1, 0, 20, 0, 0, 0},  idle,                  0, 1, 0, none,            none,           '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}};
        v = '{idle, idle, 0, 0, 0, none, none, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        apply(v, 1, 100);
        @(posedge clk);
        for (int i = 0; i < 18; i++) apply(tbl[i], 0, i);
        // reset mid-run: group is not fired and both maps clear
        v = '{'{1, 1, 7, 0, 21, 50}, idle, 0, 1, 0, none, none, '{21, 0, 0, 0, 50, 0, 0, 0, 1, 0, 0}};
        apply(v, 1, 200);
        v = '{'{1, 0, 7, 10, 0, 0}, idle, 0, 1, 0, none, none, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}};
        apply(v, 0, 201);
        v = '{'{1, 0, 7, 0, 0, 0}, idle, 0, 1, 1, none, none, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        apply(v, 0, 202);
        v = '{'{1, 0, 10, 7, 0, 0}, idle, 0, 1, 0, none, none, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}};
        apply(v, 0, 203);
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
